pdp8_iot_seq: RTL

//  Sequences PDP-8 IOT instructions onto the shared device I/O bus (pdp8_tt and peers).

---
 rtl/pdp8_iot_pkg.sv | 40 ++++
 rtl/pdp8_iot_seq_if.sv | 46 ++++
 rtl/pdp8_iot_mux.sv | 38 +++
 rtl/pdp8_iot_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pdp8_iot_pkg.sv
// Shared PDP-8 IOT bus definitions: sequencer phases, their bus state numbers and the IOT opcode.
package pdp8_iot_pkg;

  localparam int          DATA_W  = 12;
  localparam logic [2:0]  IOT_OPC = 3'o6;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_P0   = 3'd1,
    PH_P1   = 3'd2,
    PH_P2   = 3'd3,
    PH_P3   = 3'd4,
    PH_DONE = 3'd5
  } phase_e;

  // Bus state number seen by the CPU and devices; IDLE and DONE both read as 0.
  function automatic logic [3:0] phase_to_state(input phase_e ph);
    case (ph)
      PH_P1:   return 4'd1;
      PH_P2:   return 4'd2;
      PH_P3:   return 4'd3;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic is_bus_phase(input phase_e ph);
    return (ph == PH_P0) || (ph == PH_P1) || (ph == PH_P2) || (ph == PH_P3);
  endfunction

  function automatic phase_e next_bus_phase(input phase_e ph);
    case (ph)
      PH_P0:   return PH_P1;
      PH_P1:   return PH_P2;
      PH_P2:   return PH_P3;
      PH_P3:   return PH_DONE;
      default: return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pdp8_iot_seq_if.sv
// CPU request/response and device bus signals of the IOT sequencer, grouped into one interface.
interface pdp8_iot_seq_if
  import pdp8_iot_pkg::*;
#(
  parameter int NDEV = 4
) ();

  logic                   req;
  logic [DATA_W-1:0]      req_mb;
  logic [DATA_W-1:0]      req_ac;
  logic                   req_ready;
  logic                   done;
  logic                   done_skip;
  logic [DATA_W-1:0]      done_ac;
  logic                   done_nodev;
  logic                   err_multi;
  logic                   irq;
  logic [2:0]             irq_src;
  logic                   iot;
  logic [3:0]             state;
  logic [DATA_W-1:0]      mb;
  logic [5:0]             io_select;
  logic [DATA_W-1:0]      io_data_in;
  logic [NDEV-1:0]        dev_selected;
  logic [NDEV-1:0]        dev_data_avail;
  logic [NDEV-1:0]        dev_skip;
  logic [NDEV-1:0]        dev_interrupt;
  logic [DATA_W*NDEV-1:0] dev_data_out;

  // The sequencer side.
  modport slave (
    input  req, req_mb, req_ac,
    input  dev_selected, dev_data_avail, dev_skip, dev_interrupt, dev_data_out,
    output req_ready, done, done_skip, done_ac, done_nodev, err_multi, irq, irq_src,
    output iot, state, mb, io_select, io_data_in
  );

  // The CPU plus device side.
  modport master (
    output req, req_mb, req_ac,
    output dev_selected, dev_data_avail, dev_skip, dev_interrupt, dev_data_out,
    input  req_ready, done, done_skip, done_ac, done_nodev, err_multi, irq, irq_src,
    input  iot, state, mb, io_select, io_data_in
  );

endinterface

// File: rtl/pdp8_iot_mux.sv
// Combinational priority select over NDEV devices; index 0 wins. Also reduces skip and select flags.
module pdp8_iot_mux
  import pdp8_iot_pkg::*;
#(
  parameter int NDEV = 4,
  parameter int W    = DATA_W
) (
  input  logic [NDEV-1:0]   sel_i,
  input  logic [NDEV-1:0]   qual_i,
  input  logic [NDEV-1:0]   skip_i,
  input  logic [W*NDEV-1:0] data_i,
  output logic              hit_o,
  output logic [2:0]        idx_o,
  output logic [W-1:0]      data_o,
  output logic              skip_o,
  output logic              any_o,
  output logic              multi_o
);

  // Scanning from the top down leaves the lowest qualifying index as the final winner.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    data_o = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (qual_i[i]) begin
        hit_o  = 1'b1;
        idx_o  = 3'(i);
        data_o = data_i[i*W +: W];
      end
    end
  end

  assign skip_o  = |(skip_i & sel_i);
  assign any_o   = |sel_i;
  assign multi_o = $countones(sel_i) > 1;

endmodule

// File: rtl/pdp8_iot_seq.sv
// PDP-8 IOT sequencer: runs one request through bus phases 0..3 and returns skip/AC in a done pulse.
module pdp8_iot_seq
  import pdp8_iot_pkg::*;
#(
  parameter int NDEV         = 4,
  parameter int PHASE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  pdp8_iot_seq_if.slave  bus
);

  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

  phase_e            ph_q, ph_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mb_q, mb_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic              skip_r_q, skip_r_d;
  logic [DATA_W-1:0] ac_r_q, ac_r_d;
  logic              nodev_r_q, nodev_r_d;
  logic              done_skip_q, done_skip_d;
  logic [DATA_W-1:0] done_ac_q, done_ac_d;
  logic              done_nodev_q, done_nodev_d;
  logic              err_q, err_d;
  logic              irq_q, irq_d;
  logic [2:0]        irq_src_q, irq_src_d;

  logic              dev_hit;
  logic [2:0]        dev_idx_unused;
  logic [DATA_W-1:0] dev_data;
  logic              dev_skip_or;
  logic              dev_any;
  logic              dev_multi;
  logic              irq_hit;
  logic [2:0]        irq_idx;
  logic              irq_data_unused;
  logic              irq_skip_unused;
  logic              irq_any_unused;
  logic              irq_multi_unused;
  logic              phase_last;

  pdp8_iot_mux #(.NDEV(NDEV), .W(DATA_W)) u_data_mux (
    .sel_i   (bus.dev_selected),
    .qual_i  (bus.dev_selected & bus.dev_data_avail),
    .skip_i  (bus.dev_skip),
    .data_i  (bus.dev_data_out),
    .hit_o   (dev_hit),
    .idx_o   (dev_idx_unused),
    .data_o  (dev_data),
    .skip_o  (dev_skip_or),
    .any_o   (dev_any),
    .multi_o (dev_multi)
  );

  // Only the priority index of the interrupt lines matters here.
  pdp8_iot_mux #(.NDEV(NDEV), .W(1)) u_irq_mux (
    .sel_i   (bus.dev_interrupt),
    .qual_i  (bus.dev_interrupt),
    .skip_i  ('0),
    .data_i  ('0),
    .hit_o   (irq_hit),
    .idx_o   (irq_idx),
    .data_o  (irq_data_unused),
    .skip_o  (irq_skip_unused),
    .any_o   (irq_any_unused),
    .multi_o (irq_multi_unused)
  );

  assign phase_last = (cnt_q == LAST_CNT);

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    ph_d         = ph_q;
    cnt_d        = cnt_q;
    mb_d         = mb_q;
    ac_d         = ac_q;
    skip_r_d     = skip_r_q;
    ac_r_d       = ac_r_q;
    nodev_r_d    = nodev_r_q;
    done_skip_d  = done_skip_q;
    done_ac_d    = done_ac_q;
    done_nodev_d = done_nodev_q;
    err_d        = err_q;
    irq_d        = irq_hit;
    irq_src_d    = irq_idx;

    case (ph_q)
      PH_IDLE: begin
        if (bus.req) begin
          mb_d  = bus.req_mb;
          ac_d  = bus.req_ac;
          cnt_d = '0;
          if (bus.req_mb[11:9] == IOT_OPC) begin
            ph_d = PH_P0;
          end else begin
            // Non-IOT opcodes never touch the bus and complete straight away.
            ph_d         = PH_DONE;
            done_skip_d  = 1'b0;
            done_ac_d    = bus.req_ac;
            done_nodev_d = 1'b1;
          end
        end
      end
      PH_P0, PH_P1, PH_P2, PH_P3: begin
        if (dev_multi) err_d = 1'b1;
        if (phase_last) begin
          cnt_d = '0;
          ph_d  = next_bus_phase(ph_q);
          if (ph_q == PH_P1) begin
            skip_r_d  = dev_skip_or;
            nodev_r_d = !dev_any;
          end
          if (ph_q == PH_P2) ac_r_d = dev_hit ? dev_data : ac_q;
          if (ph_q == PH_P3) begin
            done_skip_d  = skip_r_q;
            done_ac_d    = ac_r_q;
            done_nodev_d = nodev_r_q;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: ph_d = PH_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q         <= PH_IDLE;
      cnt_q        <= '0;
      mb_q         <= '0;
      ac_q         <= '0;
      skip_r_q     <= 1'b0;
      ac_r_q       <= '0;
      nodev_r_q    <= 1'b0;
      done_skip_q  <= 1'b0;
      done_ac_q    <= '0;
      done_nodev_q <= 1'b0;
      err_q        <= 1'b0;
      irq_q        <= 1'b0;
      irq_src_q    <= '0;
    end else begin
      ph_q         <= ph_d;
      cnt_q        <= cnt_d;
      mb_q         <= mb_d;
      ac_q         <= ac_d;
      skip_r_q     <= skip_r_d;
      ac_r_q       <= ac_r_d;
      nodev_r_q    <= nodev_r_d;
      done_skip_q  <= done_skip_d;
      done_ac_q    <= done_ac_d;
      done_nodev_q <= done_nodev_d;
      err_q        <= err_d;
      irq_q        <= irq_d;
      irq_src_q    <= irq_src_d;
    end
  end

  assign bus.req_ready  = (ph_q == PH_IDLE);
  assign bus.done       = (ph_q == PH_DONE);
  assign bus.iot        = is_bus_phase(ph_q);
  assign bus.state      = phase_to_state(ph_q);
  assign bus.mb         = mb_q;
  assign bus.io_select  = mb_q[8:3];
  assign bus.io_data_in = ac_q;
  assign bus.done_skip  = done_skip_q;
  assign bus.done_ac    = done_ac_q;
  assign bus.done_nodev = done_nodev_q;
  assign bus.err_multi  = err_q;
  assign bus.irq        = irq_q;
  assign bus.irq_src    = irq_src_q;

endmodule
